// File: rtl/online_digit_collector_if.sv
// Handshake/bus bundle between the digit sequencer and online_digit_collector.
// conv_out exists only when OTF_CONVERT_EN is defined.
interface online_digit_collector_if #(
   parameter int no_of_digits = 4,
   parameter int radix_bits   = 3
);
   localparam int DW = (no_of_digits + 1) * radix_bits;
   localparam int CW = 2 * (no_of_digits + 1) + 1;

   logic                  start;
   logic [radix_bits-1:0] z;
   logic [DW-1:0]         dout;
   logic                  dout_valid;
   logic                  busy;
   logic                  digit_err;
`ifdef OTF_CONVERT_EN
   logic [CW-1:0]         conv_out;
`endif

   modport master (
      output start, z,
      input  dout, dout_valid, busy, digit_err
`ifdef OTF_CONVERT_EN
      , input conv_out
`endif
   );

   modport slave (
      input  start, z,
      output dout, dout_valid, busy, digit_err
`ifdef OTF_CONVERT_EN
      , output conv_out
`endif
   );
endinterface

// File: rtl/online_digit_collector.sv
// online_digit_collector: waits out the online delay after start, then captures
// no_of_digits+1 signed digits MSD first and presents them as one parallel word
// with a single-cycle valid pulse.
// Optional feature macro: OTF_CONVERT_EN (on-the-fly conversion to two's complement).
// Assumes no_of_digits >= 1 and delta >= 1.
//
// state   | meaning
// IDLE    | no frame; waiting for start
// WAIT    | online delay elapsing, z not sampled
// CAPTURE | sampling z each edge; cnt==0 marks the final capture edge
module online_digit_collector #(
   parameter int no_of_digits = 4,
   parameter int radix_bits   = 3,
   parameter int delta        = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   online_digit_collector_if.slave bus
);
   localparam int DW      = (no_of_digits + 1) * radix_bits;
   localparam int CW      = 2 * (no_of_digits + 1) + 1;
   localparam int CNT_MAX = (delta - 1 > no_of_digits + 1) ? delta - 1 : no_of_digits + 1;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [radix_bits-1:0] ILLEGAL = {1'b1, {(radix_bits-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [DW-1:0]    sr;
   logic             err_flag;
   logic             z_illegal;
   logic [DW-1:0]    sr_next;

   assign z_illegal = (bus.z == ILLEGAL);
   assign sr_next   = {sr[DW-radix_bits-1:0], bus.z};

`ifdef OTF_CONVERT_EN
   logic [CW-1:0]   q;
   logic [CW-1:0]   qm;
   logic [2*CW-1:0] step_init;
   logic [2*CW-1:0] step_cur;

   // One conversion step: returns {Q_next, QM_next}; digit 3'b100 acts as -4.
   function automatic logic [2*CW-1:0] otf_step(input logic [CW-1:0] q_in,
                                                input logic [CW-1:0] qm_in,
                                                input logic signed [2:0] d);
      logic [2:0]    a_q;
      logic [2:0]    a_qm;
      logic [CW-1:0] nq;
      logic [CW-1:0] nqm;
      a_q  = '0;
      a_qm = '0;
      if (d > 3'sd0) begin
         a_qm = d - 3'd1;
         nq   = {q_in[CW-3:0], d[1:0]};
         nqm  = {q_in[CW-3:0], a_qm[1:0]};
      end else if (d == 3'sd0) begin
         nq   = {q_in[CW-3:0], 2'b00};
         nqm  = {qm_in[CW-3:0], 2'b11};
      end else begin
         a_q  = d + 3'd4;
         a_qm = d + 3'd3;
         nq   = {qm_in[CW-3:0], a_q[1:0]};
         nqm  = {qm_in[CW-3:0], a_qm[1:0]};
      end
      return {nq, nqm};
   endfunction

   // delta==1 captures on the start edge itself, so conversion starts from reset values there.
   assign step_init = otf_step('0, '1, bus.z[2:0]);
   assign step_cur  = otf_step(q, qm, bus.z[2:0]);
`endif

   // Frame sequencer with registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         cnt            <= '0;
         sr             <= '0;
         err_flag       <= 1'b0;
         bus.dout       <= '0;
         bus.dout_valid <= 1'b0;
         bus.busy       <= 1'b0;
         bus.digit_err  <= 1'b0;
`ifdef OTF_CONVERT_EN
         q              <= '0;
         qm             <= '1;
         bus.conv_out   <= '0;
`endif
      end else begin
         bus.dout_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  bus.busy <= 1'b1;
                  if (delta == 1) begin
                     sr       <= sr_next;
                     err_flag <= z_illegal;
`ifdef OTF_CONVERT_EN
                     {q, qm}  <= step_init;
`endif
                     state    <= CAPTURE;
                     cnt      <= CNT_W'(no_of_digits - 1);
                  end else begin
                     err_flag <= 1'b0;
`ifdef OTF_CONVERT_EN
                     q        <= '0;
                     qm       <= '1;
`endif
                     if (delta == 2) begin
                        state <= CAPTURE;
                        cnt   <= CNT_W'(no_of_digits);
                     end else begin
                        state <= WAIT;
                        cnt   <= CNT_W'(delta - 3);
                     end
                  end
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  state <= CAPTURE;
                  cnt   <= CNT_W'(no_of_digits);
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            CAPTURE: begin
               sr       <= sr_next;
               err_flag <= err_flag | z_illegal;
`ifdef OTF_CONVERT_EN
               {q, qm}  <= step_cur;
`endif
               if (cnt == '0) begin
                  state          <= IDLE;
                  bus.dout       <= sr_next;
                  bus.dout_valid <= 1'b1;
                  bus.busy       <= 1'b0;
                  bus.digit_err  <= err_flag | z_illegal;
`ifdef OTF_CONVERT_EN
                  bus.conv_out   <= step_cur[2*CW-1:CW];
`endif
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_online_digit_collector.sv
// Directed bench for online_digit_collector: default instance (delta=2, 4 digits)
// plus a delta=1, 2-digit instance. Inputs change on negedge, outputs sampled on negedge.
module tb_online_digit_collector;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   logic busy_mid;
   logic valid_early;

   online_digit_collector_if #(.no_of_digits(4), .radix_bits(3)) bus ();
   online_digit_collector_if #(.no_of_digits(2), .radix_bits(3)) bus1 ();

   online_digit_collector #(.no_of_digits(4), .radix_bits(3), .delta(2)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   online_digit_collector #(.no_of_digits(2), .radix_bits(3), .delta(1)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Called at a negedge: start sampled at E0, d[4] captured at E1 .. d[0] at E5.
   // Returns just after E5; extra_start raises start on that edge index as well.
   task automatic drive_frame(input logic [4:0][2:0] d, input int extra_start,
                              input logic [2:0] z_e0);
      bus.start = 1'b1;
      bus.z     = z_e0;
      @(posedge clk);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 3) busy_mid = bus.busy;
         if (k == 5) valid_early = bus.dout_valid;
         bus.start = (k == extra_start);
         bus.z     = d[5-k];
         @(posedge clk);
      end
   endtask

   task automatic test_reset();
      checks++; if (bus.dout !== 15'd0) begin errors++; $display("FAIL reset_dout: got %h expected 0", bus.dout); end
      checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.dout_valid); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.digit_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.digit_err); end
      checks++; if (bus1.dout !== 9'd0) begin errors++; $display("FAIL reset_dout1: got %h expected 0", bus1.dout); end
`ifdef OTF_CONVERT_EN
      checks++; if (bus.conv_out !== 11'd0) begin errors++; $display("FAIL reset_conv: got %h expected 0", bus.conv_out); end
`endif
   endtask

   task automatic test_basic();
      drive_frame({3'b001, 3'b010, 3'b111, 3'b000, 3'b011}, -1, 3'b000);
      @(negedge clk);
      bus.start = 1'b0; bus.z = 3'b000;
      checks++; if (busy_mid !== 1'b1) begin errors++; $display("FAIL basic_busy_mid: got %b expected 1", busy_mid); end
      checks++; if (valid_early !== 1'b0) begin errors++; $display("FAIL basic_valid_early: got %b expected 0", valid_early); end
      checks++; if (bus.dout_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", bus.dout_valid); end
      checks++; if (bus.dout !== 15'b001_010_111_000_011) begin errors++; $display("FAIL basic_dout: got %b expected 001010111000011", bus.dout); end
      checks++; if (bus.digit_err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b expected 0", bus.digit_err); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b expected 0", bus.busy); end
      @(negedge clk);
      checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_pulse: got %b expected 0", bus.dout_valid); end
      checks++; if (bus.dout !== 15'b001_010_111_000_011) begin errors++; $display("FAIL basic_dout_hold: got %b expected 001010111000011", bus.dout); end
   endtask

   task automatic test_otf();
      drive_frame({3'b011, 3'b011, 3'b011, 3'b011, 3'b011}, -1, 3'b000);
      @(negedge clk);
      bus.start = 1'b0; bus.z = 3'b000;
      checks++; if (bus.dout !== 15'b011_011_011_011_011) begin errors++; $display("FAIL otf_dout_33333: got %b", bus.dout); end
`ifdef OTF_CONVERT_EN
      checks++; if (bus.conv_out !== 11'd1023) begin errors++; $display("FAIL otf_conv_33333: got %0d expected 1023", bus.conv_out); end
`endif
      @(negedge clk);
      drive_frame({3'b001, 3'b111, 3'b000, 3'b000, 3'b000}, -1, 3'b000);
      @(negedge clk);
      bus.start = 1'b0; bus.z = 3'b000;
      checks++; if (bus.dout !== 15'b001_111_000_000_000) begin errors++; $display("FAIL otf_dout_1m1: got %b", bus.dout); end
`ifdef OTF_CONVERT_EN
      checks++; if (bus.conv_out !== 11'd192) begin errors++; $display("FAIL otf_conv_1m1: got %0d expected 192", bus.conv_out); end
`endif
      @(negedge clk);
      drive_frame({3'b111, 3'b000, 3'b000, 3'b000, 3'b000}, -1, 3'b000);
      @(negedge clk);
      bus.start = 1'b0; bus.z = 3'b000;
      checks++; if (bus.dout !== 15'b111_000_000_000_000) begin errors++; $display("FAIL otf_dout_m1: got %b", bus.dout); end
`ifdef OTF_CONVERT_EN
      checks++; if (bus.conv_out !== 11'h700) begin errors++; $display("FAIL otf_conv_m1: got %h expected 700 (-256)", bus.conv_out); end
`endif
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      drive_frame({3'b011, 3'b101, 3'b001, 3'b000, 3'b110}, -1, 3'b000);
      @(negedge clk);
      checks++; if (bus.dout_valid !== 1'b1) begin errors++; $display("FAIL b2b_a_valid: got %b expected 1", bus.dout_valid); end
      checks++; if (bus.dout !== 15'b011_101_001_000_110) begin errors++; $display("FAIL b2b_a_dout: got %b expected 011101001000110", bus.dout); end
      drive_frame({3'b010, 3'b010, 3'b110, 3'b101, 3'b001}, 3, 3'b000);
      @(negedge clk);
      bus.start = 1'b0; bus.z = 3'b000;
      checks++; if (valid_early !== 1'b0) begin errors++; $display("FAIL b2b_b_valid_early: got %b expected 0", valid_early); end
      checks++; if (bus.dout_valid !== 1'b1) begin errors++; $display("FAIL b2b_b_valid: got %b expected 1", bus.dout_valid); end
      checks++; if (bus.dout !== 15'b010_010_110_101_001) begin errors++; $display("FAIL b2b_b_dout: got %b expected 010010110101001", bus.dout); end
      @(negedge clk);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy: got %b expected 0", bus.busy); end
   endtask

   task automatic test_digit_err();
      drive_frame({3'b001, 3'b100, 3'b000, 3'b000, 3'b000}, -1, 3'b000);
      @(negedge clk);
      bus.start = 1'b0; bus.z = 3'b000;
      checks++; if (bus.digit_err !== 1'b1) begin errors++; $display("FAIL err_flagged: got %b expected 1", bus.digit_err); end
      checks++; if (bus.dout !== 15'b001_100_000_000_000) begin errors++; $display("FAIL err_dout: got %b expected 001100000000000", bus.dout); end
      @(negedge clk);
      checks++; if (bus.digit_err !== 1'b1) begin errors++; $display("FAIL err_hold: got %b expected 1", bus.digit_err); end
      drive_frame({3'b010, 3'b001, 3'b000, 3'b111, 3'b110}, -1, 3'b000);
      @(negedge clk);
      bus.start = 1'b0; bus.z = 3'b100;
      checks++; if (bus.digit_err !== 1'b0) begin errors++; $display("FAIL err_clean_next: got %b expected 0", bus.digit_err); end
      @(negedge clk);
      drive_frame({3'b011, 3'b000, 3'b000, 3'b000, 3'b101}, -1, 3'b100);
      @(negedge clk);
      bus.start = 1'b0; bus.z = 3'b000;
      checks++; if (bus.digit_err !== 1'b0) begin errors++; $display("FAIL err_outside_window: got %b expected 0", bus.digit_err); end
      checks++; if (bus.dout !== 15'b011_000_000_000_101) begin errors++; $display("FAIL err_outside_dout: got %b expected 011000000000101", bus.dout); end
      @(negedge clk);
   endtask

   task automatic test_reset_midframe();
      int seen;
      bus.start = 1'b1; bus.z = 3'b000;
      @(posedge clk);
      bus.start = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         bus.z = 3'(k);
         @(posedge clk);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.dout !== 15'd0) begin errors++; $display("FAIL rst_mid_dout: got %h expected 0", bus.dout); end
      checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", bus.dout_valid); end
      seen = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (bus.dout_valid === 1'b1) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mid_no_valid: got %0d pulses expected 0", seen); end
      drive_frame({3'b001, 3'b001, 3'b001, 3'b001, 3'b001}, -1, 3'b000);
      @(negedge clk);
      bus.start = 1'b0; bus.z = 3'b000;
      checks++; if (bus.dout_valid !== 1'b1) begin errors++; $display("FAIL rst_fresh_valid: got %b expected 1", bus.dout_valid); end
      checks++; if (bus.dout !== 15'b001_001_001_001_001) begin errors++; $display("FAIL rst_fresh_dout: got %b expected 001001001001001", bus.dout); end
      @(negedge clk);
   endtask

   task automatic test_delta1();
      bus1.start = 1'b1; bus1.z = 3'b101;
      @(posedge clk);
      @(negedge clk);
      bus1.start = 1'b0; bus1.z = 3'b010;
      checks++; if (bus1.busy !== 1'b1) begin errors++; $display("FAIL d1_busy: got %b expected 1", bus1.busy); end
      @(posedge clk);
      @(negedge clk);
      bus1.z = 3'b011;
      checks++; if (bus1.dout_valid !== 1'b0) begin errors++; $display("FAIL d1_valid_early: got %b expected 0", bus1.dout_valid); end
      @(posedge clk);
      @(negedge clk);
      bus1.z = 3'b000;
      checks++; if (bus1.dout_valid !== 1'b1) begin errors++; $display("FAIL d1_valid: got %b expected 1", bus1.dout_valid); end
      checks++; if (bus1.dout !== 9'b101_010_011) begin errors++; $display("FAIL d1_dout: got %b expected 101010011", bus1.dout); end
      checks++; if (bus1.busy !== 1'b0) begin errors++; $display("FAIL d1_busy_end: got %b expected 0", bus1.busy); end
`ifdef OTF_CONVERT_EN
      checks++; if (bus1.conv_out !== 7'd91) begin errors++; $display("FAIL d1_conv: got %0d expected 91 (-37)", bus1.conv_out); end
`endif
      @(negedge clk);
   endtask

   // Test sequence.
   initial begin
      clk = 1'b0; rst_n = 1'b0;
      checks = 0; errors = 0;
      busy_mid = 1'b0; valid_early = 1'b0;
      bus.start = 1'b0; bus.z = 3'b000;
      bus1.start = 1'b0; bus1.z = 3'b000;
      repeat (2) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_basic();
      test_otf();
      test_back_to_back();
      test_digit_err();
      test_reset_midframe();
      test_delta1();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
